// File: rtl/vga_timing_axis_counter.sv
// vga_timing_axis_counter: registered timing counter for one VGA axis.
// Counts 0..WHOLE_FRAME-1 under advance_enable and produces zero, blanking
// and sync flags that are aligned with counter_out on the same cycle.
// wrap_pulse is combinational so a horizontal instance can step a vertical one.
// Optional build macro VGA_COUNTER_RUNTIME_LIMITS_EN adds cfg_* ports and
// shadow/active limit registers; active limits only change on a wrap edge.
module vga_timing_axis_counter #(
    parameter int COUNTER_SIZE    = 11,
    parameter int WHOLE_FRAME     = 1328,
    parameter int THRESHOLD       = 1072,
    parameter int SYNC_START      = 1096,
    parameter int SYNC_END        = 1232,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic                    control_clock,
    input  logic                    control_reset_n,
    input  logic                    advance_enable,
    input  logic                    count_clear,
`ifdef VGA_COUNTER_RUNTIME_LIMITS_EN
    input  logic                    cfg_load,
    input  logic [COUNTER_SIZE-1:0] cfg_whole_frame,
    input  logic [COUNTER_SIZE-1:0] cfg_threshold,
    input  logic [COUNTER_SIZE-1:0] cfg_sync_start,
    input  logic [COUNTER_SIZE-1:0] cfg_sync_end,
`endif
    output logic [COUNTER_SIZE-1:0] counter_out,
    output logic                    zero_detected,
    output logic                    threshold_detected,
    output logic                    sync_out,
    output logic                    wrap_pulse
);

    // The period is held as its last count so WHOLE_FRAME = 2^COUNTER_SIZE fits.
    localparam logic [COUNTER_SIZE-1:0] P_LAST = COUNTER_SIZE'(WHOLE_FRAME - 1);
    localparam logic [COUNTER_SIZE-1:0] P_THR  = COUNTER_SIZE'(THRESHOLD);
    localparam logic [COUNTER_SIZE-1:0] P_SS   = COUNTER_SIZE'(SYNC_START);
    localparam logic [COUNTER_SIZE-1:0] P_SE   = COUNTER_SIZE'(SYNC_END);
    localparam logic                    P_IDLE = 1'(SYNC_ACTIVE_LOW);

    logic [COUNTER_SIZE-1:0] w_cur_last;   // limit governing this cycle's wrap
    logic [COUNTER_SIZE-1:0] w_nxt_thr;    // limits that apply to the next count
    logic [COUNTER_SIZE-1:0] w_nxt_ss;
    logic [COUNTER_SIZE-1:0] w_nxt_se;
    logic [COUNTER_SIZE-1:0] w_next;
    logic                    w_wrap;
    logic                    w_nxt_in_sync;

`ifdef VGA_COUNTER_RUNTIME_LIMITS_EN
    logic [COUNTER_SIZE-1:0] r_last, r_thr, r_ss, r_se;
    logic [COUNTER_SIZE-1:0] r_sh_last, r_sh_thr, r_sh_ss, r_sh_se;
    logic [COUNTER_SIZE-1:0] w_cfg_last;
    logic [COUNTER_SIZE-1:0] w_nxt_last;

    // cfg_whole_frame of 0 therefore means a full 2^COUNTER_SIZE period.
    assign w_cfg_last = cfg_whole_frame - 1'b1;
    assign w_cur_last = r_last;

    // A load coinciding with the wrap bypasses the shadows so it is not lost a line.
    always_comb begin
        w_nxt_last = r_last;
        w_nxt_thr  = r_thr;
        w_nxt_ss   = r_ss;
        w_nxt_se   = r_se;
        if (w_wrap) begin
            if (cfg_load) begin
                w_nxt_last = w_cfg_last;
                w_nxt_thr  = cfg_threshold;
                w_nxt_ss   = cfg_sync_start;
                w_nxt_se   = cfg_sync_end;
            end else begin
                w_nxt_last = r_sh_last;
                w_nxt_thr  = r_sh_thr;
                w_nxt_ss   = r_sh_ss;
                w_nxt_se   = r_sh_se;
            end
        end
    end

    // Shadow registers capture the cfg_* values whenever cfg_load is high.
    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            r_sh_last <= P_LAST;
            r_sh_thr  <= P_THR;
            r_sh_ss   <= P_SS;
            r_sh_se   <= P_SE;
        end else if (cfg_load) begin
            r_sh_last <= w_cfg_last;
            r_sh_thr  <= cfg_threshold;
            r_sh_ss   <= cfg_sync_start;
            r_sh_se   <= cfg_sync_end;
        end
    end

    // Active limits move only at a line boundary so the period never changes mid-line.
    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            r_last <= P_LAST;
            r_thr  <= P_THR;
            r_ss   <= P_SS;
            r_se   <= P_SE;
        end else begin
            r_last <= w_nxt_last;
            r_thr  <= w_nxt_thr;
            r_ss   <= w_nxt_ss;
            r_se   <= w_nxt_se;
        end
    end
`else
    assign w_cur_last = P_LAST;
    assign w_nxt_thr  = P_THR;
    assign w_nxt_ss   = P_SS;
    assign w_nxt_se   = P_SE;
`endif

    // Wrap strobe: a clear in the last cycle suppresses it so cascades do not step.
    assign w_wrap     = (counter_out == w_cur_last) && advance_enable && !count_clear;
    assign wrap_pulse = w_wrap;

    // Next count in priority order: clear, hold, wrap, increment.
    always_comb begin
        w_next = counter_out;
        if (count_clear)
            w_next = '0;
        else if (!advance_enable)
            w_next = counter_out;
        else if (counter_out == w_cur_last)
            w_next = '0;
        else
            w_next = counter_out + 1'b1;
    end

    // Empty window (start >= end) can never satisfy both bounds.
    assign w_nxt_in_sync = (w_next >= w_nxt_ss) && (w_next < w_nxt_se);

    // Count and flags share one edge; flags decode the next count for zero latency.
    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            counter_out        <= '0;
            zero_detected      <= 1'b1;
            threshold_detected <= 1'b0;
            sync_out           <= P_IDLE;
        end else begin
            counter_out        <= w_next;
            zero_detected      <= (w_next == '0);
            threshold_detected <= (w_next >= w_nxt_thr);
            sync_out           <= w_nxt_in_sync ? ~P_IDLE : P_IDLE;
        end
    end

endmodule

// File: tb/tb_vga_timing_axis_counter.sv
// Directed bench for vga_timing_axis_counter: horizontal instance (period 10)
// cascaded into a vertical instance (period 3). Inputs change on the falling
// edge and outputs are checked shortly after, well before the rising edge.
module tb_vga_timing_axis_counter;

    localparam int CS = 4;

    logic          clk;
    logic          rst_n;
    logic          h_en, h_clr, v_clr;
    logic [CS-1:0] h_cnt, v_cnt;
    logic          h_zero, h_thr, h_sync, h_wrap;
    logic          v_zero, v_thr, v_sync, v_wrap;
`ifdef VGA_COUNTER_RUNTIME_LIMITS_EN
    logic          cfg_load;
    logic [CS-1:0] cfg_wf;
`endif

    int errs   = 0;
    int checks = 0;
    int m_last = 9;   // bench-side model of the horizontal last count

    vga_timing_axis_counter #(
        .COUNTER_SIZE(CS), .WHOLE_FRAME(10), .THRESHOLD(6),
        .SYNC_START(7), .SYNC_END(9), .SYNC_ACTIVE_LOW(1)
    ) u_h (
        .control_clock     (clk),
        .control_reset_n   (rst_n),
        .advance_enable    (h_en),
        .count_clear       (h_clr),
`ifdef VGA_COUNTER_RUNTIME_LIMITS_EN
        .cfg_load          (cfg_load),
        .cfg_whole_frame   (cfg_wf),
        .cfg_threshold     (4'd6),
        .cfg_sync_start    (4'd7),
        .cfg_sync_end      (4'd9),
`endif
        .counter_out       (h_cnt),
        .zero_detected     (h_zero),
        .threshold_detected(h_thr),
        .sync_out          (h_sync),
        .wrap_pulse        (h_wrap)
    );

    vga_timing_axis_counter #(
        .COUNTER_SIZE(CS), .WHOLE_FRAME(3), .THRESHOLD(2),
        .SYNC_START(1), .SYNC_END(2), .SYNC_ACTIVE_LOW(1)
    ) u_v (
        .control_clock     (clk),
        .control_reset_n   (rst_n),
        .advance_enable    (h_wrap),
        .count_clear       (v_clr),
`ifdef VGA_COUNTER_RUNTIME_LIMITS_EN
        .cfg_load          (1'b0),
        .cfg_whole_frame   (4'd3),
        .cfg_threshold     (4'd2),
        .cfg_sync_start    (4'd1),
        .cfg_sync_end      (4'd2),
`endif
        .counter_out       (v_cnt),
        .zero_detected     (v_zero),
        .threshold_detected(v_thr),
        .sync_out          (v_sync),
        .wrap_pulse        (v_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive inputs for the coming edge, check the current count and its flags,
    // then advance to the next falling edge. vexp < 0 skips the vertical check.
    task automatic step(input logic en, input logic clr, input int exp_cnt, input int vexp);
        h_en  = en;
        h_clr = clr;
        #1;
        chk("cnt",  32'(h_cnt),  32'(exp_cnt));
        chk("zero", 32'(h_zero), 32'(exp_cnt == 0));
        chk("thr",  32'(h_thr),  32'(exp_cnt >= 6));
        chk("sync", 32'(h_sync), 32'(!(exp_cnt >= 7 && exp_cnt < 9)));
        chk("wrap", 32'(h_wrap), 32'(exp_cnt == m_last && en && !clr));
        if (vexp >= 0) chk("vcnt", 32'(v_cnt), 32'(vexp));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        h_en  = 1'b0;
        h_clr = 1'b0;
        v_clr = 1'b0;
`ifdef VGA_COUNTER_RUNTIME_LIMITS_EN
        cfg_load = 1'b0;
        cfg_wf   = 4'd10;
`endif
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_cnt",  32'(h_cnt),  32'd0);
        chk("rst_zero", 32'(h_zero), 32'd1);
        chk("rst_thr",  32'(h_thr),  32'd0);
        chk("rst_sync", 32'(h_sync), 32'd1);
        chk("rst_vcnt", 32'(v_cnt),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Free run: 0..9,0,1, then on to count 4.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, i % 10, -1);
        step(1'b1, 1'b0, 2, -1);
        step(1'b1, 1'b0, 3, -1);

        // Enable toggling at count 4: reads 4,5,5,6,6 with flags frozen on holds.
        step(1'b1, 1'b0, 4, -1);
        step(1'b0, 1'b0, 5, -1);
        step(1'b1, 1'b0, 5, -1);
        step(1'b0, 1'b0, 6, -1);
        step(1'b1, 1'b0, 6, -1);

        // Clear in the last count: no wrap strobe, next count 0.
        step(1'b1, 1'b0, 7, -1);
        step(1'b1, 1'b0, 8, -1);
        step(1'b1, 1'b1, 9, -1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, i, -1);
        // Clear while held at count 5.
        step(1'b0, 1'b1, 5, -1);
        step(1'b0, 1'b0, 0, -1);

        // Run to count 7, then reset asynchronously between clock edges.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, i, -1);
        h_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt",  32'(h_cnt),  32'd0);
        chk("arst_zero", 32'(h_zero), 32'd1);
        chk("arst_thr",  32'(h_thr),  32'd0);
        chk("arst_sync", 32'(h_sync), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Cascade: vertical steps on each horizontal 9->0 edge, wrapping after 2.
        for (int i = 0; i < 31; i++) step(1'b1, 1'b0, i % 10, (i / 10) % 3);

`ifdef VGA_COUNTER_RUNTIME_LIMITS_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 9;
        // Load period 5 mid-line: this line still ends at 9.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, i, -1);
        cfg_load = 1'b1;
        cfg_wf   = 4'd5;
        step(1'b1, 1'b0, 3, -1);
        cfg_load = 1'b0;
        for (int i = 4; i < 10; i++) step(1'b1, 1'b0, i, -1);
        m_last = 4;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, i % 5, -1);
        // Load period 10 in the wrap cycle: takes effect on that same wrap.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, i, -1);
        cfg_load = 1'b1;
        cfg_wf   = 4'd10;
        step(1'b1, 1'b0, 4, -1);
        cfg_load = 1'b0;
        m_last = 9;
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, i % 10, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
